// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for the sequential binary-to-BCD converter.
// The requester uses the master modport; the converter uses the slave modport.
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W  = 6,
  parameter int unsigned DIGITS = 2
) ();

  logic                  start;
  logic [BIN_W-1:0]      data_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output start, data_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, data_in,
    output busy, done, bcd_out, ovf
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A start in IDLE loads the operand; BIN_W clocks later the result is registered
// into bcd_out together with a one-cycle done pulse. Values above 10^DIGITS-1
// saturate to all nines and raise ovf.
// Optional build macro BIN2BCD_BLANK_EN: leading zero digits above digit 0 are
// replaced by the display blank code 4'hF when the result is registered.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  bin2bcd_seq_if.slave    bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // Largest value representable in DIGITS decimal digits (needs >32 bits at 10 digits).
  function automatic logic [63:0] max_value();
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      m = m * 64'd10;
    end
    return m - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value();

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   sr;
  logic [BCD_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic               busy_q;
  logic               done_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   adj_c;
  logic [BCD_W-1:0]   acc_step_c;
  logic [BIN_W-1:0]   sr_step_c;
  logic [BCD_W-1:0]   result_c;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift left by one.
  always_comb begin
    adj_c = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_step_c = {adj_c[BCD_W-2:0], sr[BIN_W-1]};
    sr_step_c  = sr << 1;
  end

  // Value to register at completion: saturated, blanked or plain accumulator.
`ifdef BIN2BCD_BLANK_EN
  always_comb begin
    logic lead;
    lead     = 1'b1;
    result_c = acc_step_c;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (acc_step_c[4*i +: 4] == 4'd0)) begin
        result_c[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    if (ovf_pend) begin
      result_c = {DIGITS{4'h9}};
    end
  end
`else
  always_comb begin
    result_c = acc_step_c;
    if (ovf_pend) begin
      result_c = {DIGITS{4'h9}};
    end
  end
`endif

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr       <= bus.data_in;
            acc      <= '0;
            cnt      <= CNT_W'(BIN_W);
            ovf_pend <= (64'(bus.data_in) > MAX_VAL);
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_step_c;
          acc <= acc_step_c;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            bcd_q  <= result_c;
            ovf_q  <= ovf_pend;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three instances (6b/2d, 6b/1d, 10b/4d),
// expected results queued at start and compared when done pulses.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(6),  .DIGITS(2)) ifa ();
  bin2bcd_seq_if #(.BIN_W(6),  .DIGITS(1)) ifb ();
  bin2bcd_seq_if #(.BIN_W(10), .DIGITS(4)) ifc ();

  bin2bcd_seq #(.BIN_W(6),  .DIGITS(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bin2bcd_seq #(.BIN_W(6),  .DIGITS(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] qa[$];
  logic [16:0] qb[$];
  logic [16:0] qc[$];
  logic [16:0] ea, eb, ec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, bcd} by decimal division, saturation and optional blanking.
  function automatic logic [16:0] model(input int unsigned v, input int unsigned digits);
    logic [15:0] b;
    int unsigned mx;
    int unsigned x;
    mx = 1;
    for (int i = 0; i < int'(digits); i++) mx = mx * 10;
    mx = mx - 1;
    b = '0;
    if (v > mx) begin
      for (int i = 0; i < int'(digits); i++) b[4*i +: 4] = 4'h9;
      return {1'b1, b};
    end
    x = v;
    for (int i = 0; i < int'(digits); i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = int'(digits) - 1; i >= 1; i--) begin
        if (lead && (b[4*i +: 4] == 4'h0)) b[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return {1'b0, b};
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ifa.done === 1'b1) begin
      check("a_sb_pending", 64'(qa.size() != 0), 64'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        check("a_bcd", 64'(ifa.bcd_out), 64'(ea[15:0]));
        check("a_ovf", 64'(ifa.ovf), 64'(ea[16]));
        check("a_busy_at_done", 64'(ifa.busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.done === 1'b1) begin
      check("b_sb_pending", 64'(qb.size() != 0), 64'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        check("b_bcd", 64'(ifb.bcd_out), 64'(eb[15:0]));
        check("b_ovf", 64'(ifb.ovf), 64'(eb[16]));
      end
    end
  end

  always @(negedge clk) begin
    if (ifc.done === 1'b1) begin
      check("c_sb_pending", 64'(qc.size() != 0), 64'd1);
      if (qc.size() != 0) begin
        ec = qc.pop_front();
        check("c_bcd", 64'(ifc.bcd_out), 64'(ec[15:0]));
        check("c_ovf", 64'(ifc.ovf), 64'(ec[16]));
      end
    end
  end

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return ifa.done;
      1:       return ifb.done;
      default: return ifc.done;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return ifa.busy;
      1:       return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  // Called at a negedge: present start for one rising edge, optionally queue the result.
  task automatic go(input int sel, input int unsigned v, input bit push);
    case (sel)
      0: begin
        ifa.start = 1'b1; ifa.data_in = 6'(v);
        if (push) qa.push_back(model(v, 2));
      end
      1: begin
        ifb.start = 1'b1; ifb.data_in = 6'(v);
        if (push) qb.push_back(model(v, 1));
      end
      default: begin
        ifc.start = 1'b1; ifc.data_in = 10'(v);
        if (push) qc.push_back(model(v, 4));
      end
    endcase
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
  endtask

  // Counts cycles (and busy cycles) until done; bounded so a stuck DUT still ends the run.
  task automatic wait_done(input int sel, input int exp_lat, input string tag);
    int n;
    int nb;
    n = 0;
    nb = 0;
    while (!(done_of(sel) === 1'b1) && n < 100) begin
      if (busy_of(sel) === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
  endtask

  initial begin
    int unsigned v;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.data_in = '0;
    ifb.start = 1'b0; ifb.data_in = '0;
    ifc.start = 1'b0; ifc.data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_a_busy", 64'(ifa.busy), 64'd0);
    check("rst_a_done", 64'(ifa.done), 64'd0);
    check("rst_a_bcd",  64'(ifa.bcd_out), 64'd0);
    check("rst_a_ovf",  64'(ifa.ovf), 64'd0);
    check("rst_b_bcd",  64'(ifb.bcd_out), 64'd0);
    check("rst_c_bcd",  64'(ifc.bcd_out), 64'd0);

    // Basic conversion and one-cycle done pulse.
    go(0, 59, 1'b1);
    wait_done(0, 6, "a59");
    @(negedge clk);
    check("a_done_one_cycle", 64'(ifa.done), 64'd0);
    check("a_bcd_held", 64'(ifa.bcd_out), model(59, 2));

    // Zero, then back-to-back start in the done cycle.
    go(0, 0, 1'b1);
    wait_done(0, 6, "a0");
    go(0, 63, 1'b1);
    wait_done(0, 6, "a63_b2b");
    @(negedge clk);

    // Start during busy is ignored; outputs hold during conversion.
    go(0, 45, 1'b1);
    check("a_hold_during_conv", 64'(ifa.bcd_out), model(63, 2));
    @(negedge clk);
    go(0, 10, 1'b0);
    check("a_busy_after_ignored", 64'(ifa.busy), 64'd1);
    wait_done(0, 4, "a45_ignore");
    repeat (8) @(negedge clk);

    // Reset mid-conversion abandons it with no done pulse.
    go(0, 38, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("a_midrst_busy", 64'(ifa.busy), 64'd0);
    check("a_midrst_bcd",  64'(ifa.bcd_out), 64'd0);
    check("a_midrst_ovf",  64'(ifa.ovf), 64'd0);
    check("a_midrst_done", 64'(ifa.done), 64'd0);
    repeat (10) @(negedge clk);
    go(0, 21, 1'b1);
    wait_done(0, 6, "a21");

    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 63);
      go(0, v, 1'b1);
      wait_done(0, 6, "a_rand");
    end

    // Single digit: overflow saturation and boundaries around 9.
    go(1, 12, 1'b1); wait_done(1, 6, "b12");
    go(1, 7,  1'b1); wait_done(1, 6, "b7");
    go(1, 9,  1'b1); wait_done(1, 6, "b9");
    go(1, 10, 1'b1); wait_done(1, 6, "b10");
    go(1, 63, 1'b1); wait_done(1, 6, "b63");
    go(1, 0,  1'b1); wait_done(1, 6, "b0");

    // Four digits, ten-bit input.
    go(2, 1023, 1'b1); wait_done(2, 10, "c1023");
    go(2, 7,    1'b1); wait_done(2, 10, "c7");
    go(2, 0,    1'b1); wait_done(2, 10, "c0");
    go(2, 999,  1'b1); wait_done(2, 10, "c999");
    go(2, 1000, 1'b1); wait_done(2, 10, "c1000");
    for (int i = 0; i < 4; i++) begin
      v = $urandom_range(0, 1023);
      go(2, v, 1'b1);
      wait_done(2, 10, "c_rand");
    end

    repeat (4) @(negedge clk);
    check("a_sb_drained", 64'(qa.size()), 64'd0);
    check("b_sb_drained", 64'(qb.size()), 64'd0);
    check("c_sb_drained", 64'(qc.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
